// File: rtl/alu_result_log.sv
// alu_result_log: watches the committed ALU operands/control and the ALU
// result, records each settled, distinct operation into a DEPTH-entry ring
// buffer (oldest overwritten) and serves a registered, newest-first read port.
// Optional feature macro: ALU_LOG_TIMESTAMP_EN stores a free-running 32-bit
// cycle stamp with each entry and adds the rd_stamp output.
module alu_result_log #(
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int SETTLE_CYC = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          log_en,
  input  logic          clear,
  input  logic [3:0]    alu_control,
  input  logic [31:0]   alu_src1,
  input  logic [31:0]   alu_src2,
  input  logic [31:0]   alu_result,
  input  logic [AW-1:0] rd_index,
  output logic          rd_valid,
  output logic [3:0]    rd_control,
  output logic [31:0]   rd_src1,
  output logic [31:0]   rd_src2,
  output logic [31:0]   rd_result,
`ifdef ALU_LOG_TIMESTAMP_EN
  output logic [31:0]   rd_stamp,
`endif
  output logic          push,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow
);

  // Settle counter only has to reach SETTLE_CYC-1.
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [AW:0]   FULL_CNT    = DEPTH[AW:0];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_COMMIT
  } state_t;

  typedef struct packed {
    logic [3:0]  control;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] result;
`ifdef ALU_LOG_TIMESTAMP_EN
    logic [31:0] stamp;
`endif
  } entry_t;

  logic [67:0]   tuple;
  logic [67:0]   snap_q;
  logic [67:0]   last_q;
  logic          last_valid_q;
  logic          change;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic          push_w;

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  entry_t        rd_q;
  logic          rd_valid_q;
  logic [AW-1:0] rd_addr;
  logic          rd_hit;

  assign tuple  = {alu_control, alu_src1, alu_src2};
  assign change = (tuple != snap_q);

  // Settle FSM next state: restart the settle window on every input change.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (change) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (change) begin
          cnt_d = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_COMMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (!log_en) begin
      state_d = ST_IDLE;
    end
  end

  // Commit writes only when the tuple differs from the last one logged.
  assign push_w = (state_q == ST_COMMIT) && log_en &&
                  (!last_valid_q || (tuple != last_q));

`ifdef ALU_LOG_TIMESTAMP_EN
  logic [31:0] stamp_q;

  // Free-running cycle stamp, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stamp_q <= '0;
    end else begin
      stamp_q <= stamp_q + 1'b1;
    end
  end
`endif

  // Assemble the entry written in the COMMIT cycle.
  always_comb begin
    wr_entry.control = alu_control;
    wr_entry.src1    = alu_src1;
    wr_entry.src2    = alu_src2;
    wr_entry.result  = alu_result;
`ifdef ALU_LOG_TIMESTAMP_EN
    wr_entry.stamp   = stamp_q;
`endif
  end

  // Snapshot, FSM, write pointer, occupancy and dedupe bookkeeping.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q       <= '0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      last_q       <= '0;
      last_valid_q <= 1'b0;
    end else begin
      snap_q  <= tuple;
      cnt_q   <= cnt_d;
      state_q <= clear ? ST_IDLE : state_d;
      if (clear) begin
        wr_ptr_q     <= '0;
        count_q      <= '0;
        overflow_q   <= 1'b0;
        last_valid_q <= 1'b0;
      end else if (push_w) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (count_q == FULL_CNT) begin
          overflow_q <= 1'b1;
        end else begin
          count_q <= count_q + 1'b1;
        end
        last_q       <= tuple;
        last_valid_q <= 1'b1;
      end
    end
  end

  // Log storage; a clear in the same cycle discards the entry.
  // NOTE: storage has no reset; count gates every read so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push_w && !clear) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end

  assign rd_addr = wr_ptr_q - 1'b1 - rd_index;
  assign rd_hit  = ({1'b0, rd_index} < count_q);

  // Registered newest-first read; data is zeroed when the index is out of range.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_q       <= '0;
    end else begin
      rd_valid_q <= rd_hit;
      rd_q       <= rd_hit ? mem[rd_addr] : '0;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_control = rd_q.control;
  assign rd_src1    = rd_q.src1;
  assign rd_src2    = rd_q.src2;
  assign rd_result  = rd_q.result;
`ifdef ALU_LOG_TIMESTAMP_EN
  assign rd_stamp   = rd_q.stamp;
`endif
  assign push       = push_w;
  assign count      = count_q;
  assign full       = (count_q == FULL_CNT);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_alu_result_log.sv
// Self-checking bench for alu_result_log: directed scenarios plus a
// randomized run, all checked against a history-based reference model.
module tb_alu_result_log;

  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int SETTLE = 4;
  localparam int HIST   = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic          log_en;
  logic          clear;
  logic [3:0]    alu_control;
  logic [31:0]   alu_src1;
  logic [31:0]   alu_src2;
  logic [31:0]   alu_result;
  logic [AW-1:0] rd_index;
  logic          rd_valid;
  logic [3:0]    rd_control;
  logic [31:0]   rd_src1;
  logic [31:0]   rd_src2;
  logic [31:0]   rd_result;
  logic          push;
  logic [AW:0]   count;
  logic          full;
  logic          overflow;
`ifdef ALU_LOG_TIMESTAMP_EN
  logic [31:0]   rd_stamp;
`endif

  always #5 clk = ~clk;

  alu_result_log #(.DEPTH(DEPTH), .AW(AW), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk),
    .reset(reset),
    .log_en(log_en),
    .clear(clear),
    .alu_control(alu_control),
    .alu_src1(alu_src1),
    .alu_src2(alu_src2),
    .alu_result(alu_result),
    .rd_index(rd_index),
    .rd_valid(rd_valid),
    .rd_control(rd_control),
    .rd_src1(rd_src1),
    .rd_src2(rd_src2),
    .rd_result(rd_result),
`ifdef ALU_LOG_TIMESTAMP_EN
    .rd_stamp(rd_stamp),
`endif
    .push(push),
    .count(count),
    .full(full),
    .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] res;
    logic [31:0] stamp;
  } ent_t;

  // Reference model: the log as a newest-first queue plus per-cycle input history.
  ent_t        log_q[$];
  logic        m_lpv;
  logic        m_ovf;
  logic [67:0] m_last;
  logic [67:0] tup_h    [HIST];
  bit          en_h     [HIST];
  bit          clr_h    [HIST];
  bit          commit_h [HIST];
  logic        exp_push;
  logic        exp_rd_valid;
  ent_t        exp_rd;

  function automatic ent_t zero_ent();
    ent_t e;
    e.ctl = '0; e.s1 = '0; e.s2 = '0; e.res = '0; e.stamp = '0;
    return e;
  endfunction

  function automatic logic [67:0] tup_at(input int c);
    return (c < 0) ? 68'd0 : tup_h[c];
  endfunction

  function automatic logic [67:0] cur_tup();
    return {alu_control, alu_src1, alu_src2};
  endfunction

  // Mid-cycle: record inputs and decide whether this cycle commits.
  // A commit happens SETTLE+1 cycles after a change, if the tuple then held,
  // capture stayed enabled, no clear intervened and the change did not land
  // on a commit cycle.
  task automatic model_eval();
    bit cm;
    int c;
    @(negedge clk);
    tup_h[cyc] = cur_tup();
    en_h[cyc]  = log_en;
    clr_h[cyc] = clear;
    c  = cyc - SETTLE - 1;
    cm = 1'b0;
    if (c >= 0) begin
      cm = (tup_at(c) != tup_at(c - 1)) && !commit_h[c];
      for (int k = c; k < cyc; k++) if (!en_h[k] || clr_h[k]) cm = 1'b0;
      for (int k = c + 1; k < cyc; k++) if (tup_h[k] != tup_h[k - 1]) cm = 1'b0;
    end
    commit_h[cyc] = cm;
    exp_push = cm && log_en && (!m_lpv || (cur_tup() != m_last));
  endtask

  // End of cycle: predict next read data, apply clear/push, move to next cycle.
  task automatic model_advance();
    ent_t e;
    exp_rd_valid = (int'(rd_index) < log_q.size());
    exp_rd       = exp_rd_valid ? log_q[rd_index] : zero_ent();
    if (clear) begin
      log_q.delete();
      m_lpv = 1'b0;
      m_ovf = 1'b0;
    end else if (exp_push) begin
      e.ctl = alu_control; e.s1 = alu_src1; e.s2 = alu_src2;
      e.res = alu_result;  e.stamp = 32'(cyc);
      log_q.push_front(e);
      if (log_q.size() > DEPTH) begin
        void'(log_q.pop_back());
        m_ovf = 1'b1;
      end
      m_lpv  = 1'b1;
      m_last = cur_tup();
    end
    @(posedge clk);
    #1;
    cyc++;
    rd_index = AW'($urandom_range(DEPTH - 1, 0));
  endtask

  task automatic do_reset();
    reset = 1'b1; log_en = 1'b0; clear = 1'b0; rd_index = '0;
    alu_control = '0; alu_src1 = '0; alu_src2 = '0; alu_result = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    log_q.delete();
    m_lpv = 1'b0; m_ovf = 1'b0; m_last = '0;
    exp_push = 1'b0; exp_rd_valid = 1'b0; exp_rd = zero_ent();
  endtask

  task automatic test_reset();
    do_reset();
    model_eval();
    checks++;
    if (push !== 1'b0) begin errors++; $display("FAIL reset_push got %0b exp 0", push); end
    checks++;
    if ({count, full, overflow} !== '0) begin
      errors++; $display("FAIL reset_status got count=%0d full=%0b ovf=%0b exp all 0", count, full, overflow);
    end
    checks++;
    if ({rd_valid, rd_control, rd_src1, rd_src2, rd_result} !== '0) begin
      errors++; $display("FAIL reset_rd got valid=%0b ctl=%h s1=%h s2=%h res=%h exp all 0",
                         rd_valid, rd_control, rd_src1, rd_src2, rd_result);
    end
`ifdef ALU_LOG_TIMESTAMP_EN
    checks++;
    if (rd_stamp !== 32'd0) begin errors++; $display("FAIL reset_stamp got %h exp 0", rd_stamp); end
`endif
    model_advance();
  endtask

  task automatic test_basic();
    log_en = 1'b1; clear = 1'b0;
    alu_control = 4'h1; alu_src1 = 32'h5; alu_src2 = 32'h3; alu_result = 32'h8;
    for (int k = 0; k < 8; k++) begin
      model_eval();
      checks++;
      if (push !== exp_push || push !== (k == 5)) begin
        errors++; $display("FAIL basic_push k=%0d got %0b exp %0b", k, push, (k == 5));
      end
      if (k == 6) begin
        checks++;
        if (count !== 4'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", count); end
      end
      if (k == 7) begin
        checks++;
        if ({rd_valid, rd_control, rd_src1, rd_src2, rd_result} !== {1'b1, 4'h1, 32'h5, 32'h3, 32'h8}) begin
          errors++; $display("FAIL basic_read got valid=%0b ctl=%h s1=%h s2=%h res=%h exp 1/1/5/3/8",
                             rd_valid, rd_control, rd_src1, rd_src2, rd_result);
        end
      end
      model_advance();
      if (k == 5) rd_index = '0;
    end
  endtask

  task automatic test_toggle();
    int npush = 0;
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) alu_src2 = ($urandom & 32'hFFFF_FF00) | 32'(k + 16);
      model_eval();
      checks++;
      if (push !== exp_push || push !== 1'b0) begin
        errors++; $display("FAIL toggle_quiet k=%0d got %0b exp 0", k, push);
      end
      model_advance();
    end
    for (int k = 0; k < 8; k++) begin
      model_eval();
      if (push === 1'b1) npush++;
      checks++;
      if (push !== exp_push || push !== (k == 3)) begin
        errors++; $display("FAIL toggle_settle k=%0d got %0b exp %0b", k, push, (k == 3));
      end
      model_advance();
    end
    checks++;
    if (npush != 1) begin errors++; $display("FAIL toggle_pushes got %0d exp 1", npush); end
  endtask

  task automatic test_dedupe();
    logic [31:0] p_src1;
    int npush = 0;
    p_src1 = alu_src1;
    for (int k = 0; k < 12; k++) begin
      alu_src1 = (k < 2) ? (p_src1 ^ 32'h1) : p_src1;
      model_eval();
      if (push === 1'b1) npush++;
      checks++;
      if (push !== exp_push || push !== 1'b0) begin
        errors++; $display("FAIL dedupe_push k=%0d got %0b exp 0", k, push);
      end
      model_advance();
    end
    checks++;
    if (npush != 0) begin errors++; $display("FAIL dedupe_pushes got %0d exp 0", npush); end
  endtask

  task automatic test_wrap();
    clear = 1'b1;
    model_eval();
    model_advance();
    clear = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      alu_src1 = 32'(i); alu_control = 4'($urandom); alu_src2 = $urandom;
      for (int k = 0; k < 6; k++) begin
        alu_result = $urandom;
        model_eval();
        checks++;
        if (push !== exp_push || push !== (k == 5)) begin
          errors++; $display("FAIL wrap_push i=%0d k=%0d got %0b exp %0b", i, k, push, (k == 5));
        end
        model_advance();
      end
    end
    rd_index = '0;
    model_eval();
    checks++;
    if ({count, full, overflow} !== {4'd8, 1'b1, 1'b1}) begin
      errors++; $display("FAIL wrap_status got count=%0d full=%0b ovf=%0b exp 8/1/1", count, full, overflow);
    end
    model_advance();
    rd_index = AW'(7);
    model_eval();
    checks++;
    if (rd_valid !== 1'b1 || rd_src1 !== 32'd10 || rd_result !== exp_rd.res) begin
      errors++; $display("FAIL wrap_newest got valid=%0b s1=%0d res=%h exp 1/10/%h", rd_valid, rd_src1, rd_result, exp_rd.res);
    end
    model_advance();
    model_eval();
    checks++;
    if (rd_valid !== 1'b1 || rd_src1 !== 32'd3 || rd_src2 !== exp_rd.s2) begin
      errors++; $display("FAIL wrap_oldest got valid=%0b s1=%0d s2=%h exp 1/3/%h", rd_valid, rd_src1, rd_src2, exp_rd.s2);
    end
    model_advance();
  endtask

  task automatic test_clear_commit();
    logic [31:0] v;
    alu_src1 = 32'hC0DE_0000 | ($urandom & 32'hFFFF);
    for (int k = 0; k < 7; k++) begin
      clear = (k == 5);
      model_eval();
      checks++;
      if (push !== exp_push || push !== (k == 5)) begin
        errors++; $display("FAIL clr_push k=%0d got %0b exp %0b", k, push, (k == 5));
      end
      if (k == 6) begin
        checks++;
        if ({count, full, overflow} !== '0) begin
          errors++; $display("FAIL clr_status got count=%0d full=%0b ovf=%0b exp 0/0/0", count, full, overflow);
        end
      end
      model_advance();
    end
    clear = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      rd_index = AW'(i);
      model_eval();
      if (i > 0) begin
        checks++;
        if ({rd_valid, rd_control, rd_src1, rd_src2, rd_result} !== '0) begin
          errors++; $display("FAIL clr_read idx=%0d got valid=%0b s1=%h exp 0", i - 1, rd_valid, rd_src1);
        end
      end
      model_advance();
    end
    v = 32'hBEEF_0000 | ($urandom & 32'hFFFF);
    alu_src1 = v;
    for (int k = 0; k < 8; k++) begin
      model_eval();
      checks++;
      if (push !== exp_push || push !== (k == 5)) begin
        errors++; $display("FAIL clr_relog k=%0d got %0b exp %0b", k, push, (k == 5));
      end
      if (k == 6) begin
        checks++;
        if (count !== 4'd1) begin errors++; $display("FAIL clr_count got %0d exp 1", count); end
      end
      if (k == 7) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_src1 !== v) begin
          errors++; $display("FAIL clr_entry0 got valid=%0b s1=%h exp 1/%h", rd_valid, rd_src1, v);
        end
      end
      model_advance();
      if (k == 5) rd_index = '0;
    end
  endtask

  task automatic test_en_drop();
    alu_src1 = 32'h0A0A_0000 | ($urandom & 32'hFFFF);
    for (int k = 0; k < 12; k++) begin
      log_en = (k != 2);
      model_eval();
      checks++;
      if (push !== exp_push || push !== 1'b0) begin
        errors++; $display("FAIL endrop_push k=%0d got %0b exp 0", k, push);
      end
      model_advance();
    end
    log_en = 1'b1;
  endtask

  task automatic test_random();
    int hold = 0;
    logic [107:0] obs, exp_v;
    for (int n = 0; n < 600; n++) begin
      if (hold == 0) begin
        alu_control = 4'($urandom_range(0, 3));
        alu_src1    = 32'($urandom_range(0, 3));
        alu_src2    = 32'($urandom_range(0, 3));
        hold        = $urandom_range(1, 8);
      end
      hold--;
      alu_result = $urandom;
      log_en     = ($urandom_range(0, 15) != 0);
      clear      = ($urandom_range(0, 49) == 0);
      model_eval();
      obs   = {push, count, full, overflow, rd_valid, rd_control, rd_src1, rd_src2, rd_result};
      exp_v = {exp_push, 4'(log_q.size()), (log_q.size() == DEPTH), m_ovf, exp_rd_valid,
               exp_rd.ctl, exp_rd.s1, exp_rd.s2, exp_rd.res};
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL rand_cycle n=%0d got %h exp %h", n, obs, exp_v);
      end
`ifdef ALU_LOG_TIMESTAMP_EN
      checks++;
      if (rd_stamp !== exp_rd.stamp) begin
        errors++; $display("FAIL rand_stamp n=%0d got %0d exp %0d", n, rd_stamp, exp_rd.stamp);
      end
`endif
      model_advance();
    end
    clear = 1'b0; log_en = 1'b1;
  endtask

`ifdef ALU_LOG_TIMESTAMP_EN
  task automatic test_stamp();
    do_reset();
    log_en = 1'b1;
    while (cyc < 260) begin
      if (cyc == 95)  alu_src1 = 32'h0000_1001;
      if (cyc == 245) alu_src1 = 32'h0000_2002;
      model_eval();
      checks++;
      if (push !== exp_push || push !== (cyc == 100 || cyc == 250)) begin
        errors++; $display("FAIL stamp_push cyc=%0d got %0b exp %0b", cyc, push, (cyc == 100 || cyc == 250));
      end
      model_advance();
    end
    rd_index = '0;
    model_eval();
    model_advance();
    rd_index = AW'(1);
    model_eval();
    checks++;
    if (rd_stamp !== 32'd250 || rd_stamp !== exp_rd.stamp) begin
      errors++; $display("FAIL stamp_newest got %0d exp 250", rd_stamp);
    end
    model_advance();
    model_eval();
    checks++;
    if (rd_stamp !== 32'd100 || rd_stamp !== exp_rd.stamp) begin
      errors++; $display("FAIL stamp_older got %0d exp 100", rd_stamp);
    end
    model_advance();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_dedupe();
    test_wrap();
    test_clear_commit();
    test_en_drop();
    test_random();
`ifdef ALU_LOG_TIMESTAMP_EN
    test_stamp();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
